// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared defines for the EX/MEM pipeline register.
// Holds bus widths, the NOP aluop code, zero constants, the stall-vector
// bit indices and the advance/bubble/hold/flush decision encoding.
package ex_mem_pkg;

    localparam int REG_BUS        = 32;
    localparam int REG_ADDR_BUS   = 5;
    localparam int ALU_OP_BUS     = 8;
    localparam int DOUBLE_REG_BUS = 64;
    localparam int STALL_BUS      = 6;
    localparam int CNT_BUS        = 2;

    // Stall-vector bit positions driven by ctrl
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    localparam logic [ALU_OP_BUS-1:0]     ALU_NOP    = 8'h00;
    localparam logic [REG_BUS-1:0]        ZERO_WORD  = 32'h0000_0000;
    localparam logic [DOUBLE_REG_BUS-1:0] ZERO_DWORD = 64'h0000_0000_0000_0000;
    localparam logic [REG_ADDR_BUS-1:0]   NOP_REG    = 5'b00000;
    localparam logic [CNT_BUS-1:0]        ZERO_CNT   = 2'b00;

    // What the register does on the coming clock edge
    typedef enum logic [1:0] {
        SEL_ADVANCE = 2'b00,
        SEL_BUBBLE  = 2'b01,
        SEL_HOLD    = 2'b10,
        SEL_FLUSH   = 2'b11
    } pipe_sel_e;

endpackage : ex_mem_pkg

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register of the five-stage MIPS core.
// Captures the EX writeback request, HI/LO update and memory-access operands
// and presents them to MEM one cycle later. Implements flush > bubble >
// advance > hold. With macro MADD_EN defined it also latches the
// multiply-accumulate partial product and counter (hilo_o/cnt_o) during a
// bubble and returns them to EX; without MADD_EN those outputs are tied 0.
// Ports:
//   clk, rst (async, active-low), stall[5:0], flush
//   ex_*  : fields from the execute stage
//   mem_* : registered copies presented to the memory stage
//   hilo_o, cnt_o : MADD/MSUB intermediate state returned to EX
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_BUS-1:0]      stall,
    input  logic                      flush,
    input  logic [REG_ADDR_BUS-1:0]   ex_waddr_reg,
    input  logic                      ex_we_reg,
    input  logic [REG_BUS-1:0]        ex_wdata,
    input  logic [REG_BUS-1:0]        ex_hi,
    input  logic [REG_BUS-1:0]        ex_lo,
    input  logic                      ex_whilo,
    input  logic [ALU_OP_BUS-1:0]     ex_aluop,
    input  logic [REG_BUS-1:0]        ex_mem_addr,
    input  logic [REG_BUS-1:0]        ex_rdata2,
    input  logic [DOUBLE_REG_BUS-1:0] ex_hilo_temp,
    input  logic [CNT_BUS-1:0]        ex_cnt,
    output logic [REG_ADDR_BUS-1:0]   mem_waddr_reg,
    output logic                      mem_we_reg,
    output logic [REG_BUS-1:0]        mem_wdata,
    output logic [REG_BUS-1:0]        mem_hi,
    output logic [REG_BUS-1:0]        mem_lo,
    output logic                      mem_whilo,
    output logic [ALU_OP_BUS-1:0]     mem_aluop,
    output logic [REG_BUS-1:0]        mem_mem_addr,
    output logic [REG_BUS-1:0]        mem_rdata2,
    output logic [DOUBLE_REG_BUS-1:0] hilo_o,
    output logic [CNT_BUS-1:0]        cnt_o
);

    pipe_sel_e sel_s;

    logic [REG_ADDR_BUS-1:0] waddr_r;
    logic                    we_r;
    logic [REG_BUS-1:0]      wdata_r;
    logic [REG_BUS-1:0]      hi_r;
    logic [REG_BUS-1:0]      lo_r;
    logic                    whilo_r;
    logic [ALU_OP_BUS-1:0]   aluop_r;
    logic [REG_BUS-1:0]      mem_addr_r;
    logic [REG_BUS-1:0]      rdata2_r;

    // Decide the edge action; stall[3]=0 with stall[4]=1 falls into advance
    always_comb begin
        sel_s = SEL_ADVANCE;
        if (flush) begin
            sel_s = SEL_FLUSH;
        end else if (!stall[STALL_EX]) begin
            sel_s = SEL_ADVANCE;
        end else if (!stall[STALL_MEM]) begin
            sel_s = SEL_BUBBLE;
        end else begin
            sel_s = SEL_HOLD;
        end
    end

    // Pipeline fields toward MEM: capture on advance, zero on flush/bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr_r    <= NOP_REG;
            we_r       <= 1'b0;
            wdata_r    <= ZERO_WORD;
            hi_r       <= ZERO_WORD;
            lo_r       <= ZERO_WORD;
            whilo_r    <= 1'b0;
            aluop_r    <= ALU_NOP;
            mem_addr_r <= ZERO_WORD;
            rdata2_r   <= ZERO_WORD;
        end else begin
            case (sel_s)
                SEL_ADVANCE: begin
                    waddr_r    <= ex_waddr_reg;
                    we_r       <= ex_we_reg;
                    wdata_r    <= ex_wdata;
                    hi_r       <= ex_hi;
                    lo_r       <= ex_lo;
                    whilo_r    <= ex_whilo;
                    aluop_r    <= ex_aluop;
                    mem_addr_r <= ex_mem_addr;
                    rdata2_r   <= ex_rdata2;
                end
                SEL_HOLD: begin
                    waddr_r    <= waddr_r;
                    we_r       <= we_r;
                    wdata_r    <= wdata_r;
                    hi_r       <= hi_r;
                    lo_r       <= lo_r;
                    whilo_r    <= whilo_r;
                    aluop_r    <= aluop_r;
                    mem_addr_r <= mem_addr_r;
                    rdata2_r   <= rdata2_r;
                end
                default: begin
                    // Flush and bubble both insert a NOP into MEM
                    waddr_r    <= NOP_REG;
                    we_r       <= 1'b0;
                    wdata_r    <= ZERO_WORD;
                    hi_r       <= ZERO_WORD;
                    lo_r       <= ZERO_WORD;
                    whilo_r    <= 1'b0;
                    aluop_r    <= ALU_NOP;
                    mem_addr_r <= ZERO_WORD;
                    rdata2_r   <= ZERO_WORD;
                end
            endcase
        end
    end

    assign mem_waddr_reg = waddr_r;
    assign mem_we_reg    = we_r;
    assign mem_wdata     = wdata_r;
    assign mem_hi        = hi_r;
    assign mem_lo        = lo_r;
    assign mem_whilo     = whilo_r;
    assign mem_aluop     = aluop_r;
    assign mem_mem_addr  = mem_addr_r;
    assign mem_rdata2    = rdata2_r;

`ifdef MADD_EN
    logic [DOUBLE_REG_BUS-1:0] hilo_r;
    logic [CNT_BUS-1:0]        cnt_r;

    // MADD/MSUB feedback: latched only while EX is bubbling, cleared on advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hilo_r <= ZERO_DWORD;
            cnt_r  <= ZERO_CNT;
        end else begin
            case (sel_s)
                SEL_BUBBLE: begin
                    hilo_r <= ex_hilo_temp;
                    cnt_r  <= ex_cnt;
                end
                SEL_HOLD: begin
                    hilo_r <= hilo_r;
                    cnt_r  <= cnt_r;
                end
                default: begin
                    hilo_r <= ZERO_DWORD;
                    cnt_r  <= ZERO_CNT;
                end
            endcase
        end
    end

    assign hilo_o = hilo_r;
    assign cnt_o  = cnt_r;

    // Stall bits not owned by this stage are intentionally ignored
    logic unused_s;
    assign unused_s = ^{stall[5], stall[2:0]};
`else
    assign hilo_o = ZERO_DWORD;
    assign cnt_o  = ZERO_CNT;

    // MADD inputs stay as ports but carry no meaning in this build
    logic unused_s;
    assign unused_s = ^{stall[5], stall[2:0], ex_hilo_temp, ex_cnt};
`endif

endmodule : ex_mem
